// File: rtl/ex_stage.sv
// Execute stage: ALU, data-SRAM address/strobe generation, mult/multu, iterative div/divu, HI/LO.
// Latency: outputs are combinational from the registered ID->EX bus; divide takes 33 cycles (1 for /0).
// Backpressure: stall[2] holds or bubbles the input register; stallreq_for_ex holds upstream during a divide.
module ex_stage #(
  parameter int ID_TO_EX_WD  = 159,
  parameter int EX_TO_MEM_WD = 76,
  parameter int STALL_WD     = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [STALL_WD-1:0]     stall,
  input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
  output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  output logic [37:0]             ex_to_rf_bus,
  output logic                    data_sram_en,
  output logic [3:0]              data_sram_wen,
  output logic [31:0]             data_sram_addr,
  output logic [31:0]             data_sram_wdata,
  output logic                    stallreq_for_ex
);

  typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_t;

  logic [ID_TO_EX_WD-1:0] id_ex_r;

  // Input register: reset, bubble when EX stalls but MEM moves, load when EX moves, else hold
  always_ff @(posedge clk) begin
    if (!rst)
      id_ex_r <= '0;
    else if (stall[2] && !stall[3])
      id_ex_r <= '0;
    else if (!stall[2])
      id_ex_r <= id_to_ex_bus;
  end

  logic [31:0] pc, inst, rs_data, rt_data;
  logic [11:0] alu_op;
  logic [2:0]  sel_alu_src1;
  logic [3:0]  sel_alu_src2;
  logic        data_ram_en, rf_we, sel_rf_res;
  logic [3:0]  data_ram_wen;
  logic [4:0]  rf_waddr;

  assign pc           = id_ex_r[158:127];
  assign inst         = id_ex_r[126:95];
  assign alu_op       = id_ex_r[94:83];
  assign sel_alu_src1 = id_ex_r[82:80];
  assign sel_alu_src2 = id_ex_r[79:76];
  assign data_ram_en  = id_ex_r[75];
  assign data_ram_wen = id_ex_r[74:71];
  assign rf_we        = id_ex_r[70];
  assign rf_waddr     = id_ex_r[69:65];
  assign sel_rf_res   = id_ex_r[64];
  assign rs_data      = id_ex_r[63:32];
  assign rt_data      = id_ex_r[31:0];

  // Local decode of the few instructions this stage treats specially
  logic [5:0] opcode, funct;
  logic inst_valid, is_special;
  logic is_mult, is_multu, is_div, is_divu, is_mfhi, is_mflo, is_mthi, is_mtlo;
  logic is_sb, is_sh, is_sw, is_div_any;

  assign opcode     = inst[31:26];
  assign funct      = inst[5:0];
  assign inst_valid = |id_ex_r;
  assign is_special = inst_valid && (opcode == 6'h00);
  assign is_mfhi    = is_special && (funct == 6'h10);
  assign is_mthi    = is_special && (funct == 6'h11);
  assign is_mflo    = is_special && (funct == 6'h12);
  assign is_mtlo    = is_special && (funct == 6'h13);
  assign is_mult    = is_special && (funct == 6'h18);
  assign is_multu   = is_special && (funct == 6'h19);
  assign is_div     = is_special && (funct == 6'h1A);
  assign is_divu    = is_special && (funct == 6'h1B);
  assign is_sb      = inst_valid && (opcode == 6'h28);
  assign is_sh      = inst_valid && (opcode == 6'h29);
  assign is_sw      = inst_valid && (opcode == 6'h2B);
  assign is_div_any = is_div || is_divu;

  // Operand selection
  logic [31:0] src1, src2;
  logic [4:0]  shamt;

  assign src1 = sel_alu_src1[1] ? pc :
                sel_alu_src1[2] ? {27'd0, inst[10:6]} : rs_data;
  assign src2 = sel_alu_src2[1] ? {{16{inst[15]}}, inst[15:0]} :
                sel_alu_src2[2] ? 32'd8 :
                sel_alu_src2[3] ? {16'd0, inst[15:0]} : rt_data;
  assign shamt = src1[4:0];

  // One-hot ALU: each result is masked by its op bit and OR-ed together
  logic [31:0] sra_res, slt_res, sltu_res, alu_res;

  assign sra_res  = $unsigned($signed(src2) >>> shamt);
  assign slt_res  = {31'd0, ($signed(src1) < $signed(src2))};
  assign sltu_res = {31'd0, (src1 < src2)};
  assign alu_res  = ({32{alu_op[11]}} & (src1 + src2))
                  | ({32{alu_op[10]}} & (src1 - src2))
                  | ({32{alu_op[9]}}  & slt_res)
                  | ({32{alu_op[8]}}  & sltu_res)
                  | ({32{alu_op[7]}}  & (src1 & src2))
                  | ({32{alu_op[6]}}  & ~(src1 | src2))
                  | ({32{alu_op[5]}}  & (src1 | src2))
                  | ({32{alu_op[4]}}  & (src1 ^ src2))
                  | ({32{alu_op[3]}}  & (src2 << shamt))
                  | ({32{alu_op[2]}}  & (src2 >> shamt))
                  | ({32{alu_op[1]}}  & sra_res)
                  | ({32{alu_op[0]}}  & {src2[15:0], 16'h0});

  // Multiplier products, sign- or zero-extended to 64 bits before multiplying
  logic [63:0] prod_s, prod_u;
  assign prod_s = $unsigned($signed({{32{rs_data[31]}}, rs_data}) * $signed({{32{rt_data[31]}}, rt_data}));
  assign prod_u = {32'd0, rs_data} * {32'd0, rt_data};

  // Divider datapath: restoring step on magnitudes, sign fixed up at the end
  div_state_t  div_state;
  logic [4:0]  div_cnt;
  logic [31:0] quo_r, rem_r, dvs_r, hi_r, lo_r;
  logic        qsign_r, rsign_r;
  logic [31:0] abs_rs, abs_rt, quo_fix, rem_fix;
  logic [32:0] trial, diff;

  assign abs_rs  = (is_div && rs_data[31]) ? (~rs_data + 32'd1) : rs_data;
  assign abs_rt  = (is_div && rt_data[31]) ? (~rt_data + 32'd1) : rt_data;
  assign trial   = {rem_r, quo_r[31]};
  assign diff    = trial - {1'b0, dvs_r};
  assign quo_fix = qsign_r ? (~quo_r + 32'd1) : quo_r;
  assign rem_fix = rsign_r ? (~rem_r + 32'd1) : rem_r;

  // Divider FSM plus HI/LO ownership; a finishing divide takes precedence over other HI/LO writers
  always_ff @(posedge clk) begin
    if (!rst) begin
      div_state <= DIV_IDLE;
      div_cnt   <= 5'd0;
      quo_r     <= 32'd0;
      rem_r     <= 32'd0;
      dvs_r     <= 32'd0;
      qsign_r   <= 1'b0;
      rsign_r   <= 1'b0;
      hi_r      <= 32'd0;
      lo_r      <= 32'd0;
    end else begin
      case (div_state)
        DIV_IDLE: begin
          if (is_div_any) begin
            if (rt_data == 32'd0) begin
              quo_r     <= 32'hFFFF_FFFF;
              rem_r     <= rs_data;
              qsign_r   <= 1'b0;
              rsign_r   <= 1'b0;
              div_state <= DIV_DONE;
            end else begin
              quo_r     <= abs_rs;
              rem_r     <= 32'd0;
              dvs_r     <= abs_rt;
              qsign_r   <= is_div && (rs_data[31] ^ rt_data[31]);
              rsign_r   <= is_div && rs_data[31];
              div_cnt   <= 5'd0;
              div_state <= DIV_BUSY;
            end
          end
        end
        DIV_BUSY: begin
          if (!diff[32]) begin
            rem_r <= diff[31:0];
            quo_r <= {quo_r[30:0], 1'b1};
          end else begin
            rem_r <= trial[31:0];
            quo_r <= {quo_r[30:0], 1'b0};
          end
          if (div_cnt == 5'd31)
            div_state <= DIV_DONE;
          else
            div_cnt <= div_cnt + 5'd1;
        end
        DIV_DONE: begin
          if (!stall[2]) begin
            hi_r      <= rem_fix;
            lo_r      <= quo_fix;
            div_state <= DIV_IDLE;
          end
        end
        default: div_state <= DIV_IDLE;
      endcase

      if (div_state != DIV_DONE && !stall[2] && inst_valid) begin
        if (is_mthi) hi_r <= rs_data;
        if (is_mtlo) lo_r <= rs_data;
        if (is_mult) begin
          hi_r <= prod_s[63:32];
          lo_r <= prod_s[31:0];
        end
        if (is_multu) begin
          hi_r <= prod_u[63:32];
          lo_r <= prod_u[31:0];
        end
      end
    end
  end

  assign stallreq_for_ex = ((div_state == DIV_IDLE) && is_div_any) || (div_state == DIV_BUSY);

  // Result and memory interface
  logic [31:0] ex_result;
  assign ex_result = is_mfhi ? hi_r : is_mflo ? lo_r : alu_res;

  assign data_sram_en   = data_ram_en;
  assign data_sram_addr = alu_res;
  assign data_sram_wen  = is_sb ? (4'b0001 << alu_res[1:0]) :
                          is_sh ? (4'b0011 << {alu_res[1], 1'b0}) :
                          is_sw ? 4'b1111 : 4'b0000;
  assign data_sram_wdata = is_sb ? {4{rt_data[7:0]}} :
                           is_sh ? {2{rt_data[15:0]}} :
                           is_sw ? rt_data : 32'd0;

  assign ex_to_mem_bus = {pc, data_ram_en, data_ram_wen, sel_rf_res, rf_we, rf_waddr, ex_result};
  assign ex_to_rf_bus  = {rf_we, rf_waddr, ex_result};

  logic unused_ok;
  assign unused_ok = ^{stall[STALL_WD-1:4], stall[1:0], inst[25:16], sel_alu_src1[0], sel_alu_src2[0]};

endmodule

// File: tb/tb_ex_stage.sv
// Randomized bench for ex_stage against a behavioural model of ALU, stores, HI/LO, mult and div.
// Latency: one clock from bus presentation to checked outputs; divides checked for stall length.
// Backpressure: the bench plays the hazard unit, stalling stages 0..2 while stallreq_for_ex is high.
module tb_ex_stage;

  logic        clk;
  logic        rst;
  logic [5:0]  stall, stall_ovr;
  logic [158:0] id_to_ex_bus;
  logic [75:0] ex_to_mem_bus;
  logic [37:0] ex_to_rf_bus;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic        stallreq_for_ex;

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] hi_m, lo_m;

  ex_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .id_to_ex_bus(id_to_ex_bus),
    .ex_to_mem_bus(ex_to_mem_bus), .ex_to_rf_bus(ex_to_rf_bus),
    .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .stallreq_for_ex(stallreq_for_ex)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [75:0] got, input logic [75:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [158:0] mk(input logic [31:0] pc, input logic [31:0] inst,
      input logic [11:0] op, input logic [2:0] s1, input logic [3:0] s2, input logic en,
      input logic [3:0] wen, input logic we, input logic [4:0] wa, input logic sr,
      input logic [31:0] rs, input logic [31:0] rt);
    return {pc, inst, op, s1, s2, en, wen, we, wa, sr, rs, rt};
  endfunction

  function automatic logic [31:0] rtype(input logic [5:0] funct);
    return {6'h00, 20'h0, funct};
  endfunction

  function automatic logic [31:0] alu_ref(input int k, input logic [31:0] a, input logic [31:0] b);
    case (k)
      0:  return a + b;
      1:  return a - b;
      2:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3:  return (a < b) ? 32'd1 : 32'd0;
      4:  return a & b;
      5:  return ~(a | b);
      6:  return a | b;
      7:  return a ^ b;
      8:  return b << a[4:0];
      9:  return b >> a[4:0];
      10: return $unsigned($signed(b) >>> a[4:0]);
      11: return {b[15:0], 16'h0};
      default: return 32'd0;
    endcase
  endfunction

  // One clock; the bench stalls stages 0..2 whenever EX asks
  task automatic step();
    stall = stall_ovr | (stallreq_for_ex ? 6'h07 : 6'h00);
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [158:0] b);
    id_to_ex_bus = b;
    step();
    id_to_ex_bus = '0;
  endtask

  task automatic read_hilo();
    issue(mk(32'hBFC0_0100, rtype(6'h10), 12'h0, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd2, 1'b0, 32'd0, 32'd0));
    chk("mfhi", 76'(ex_to_mem_bus[31:0]), 76'(hi_m));
    issue(mk(32'hBFC0_0104, rtype(6'h12), 12'h0, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd2, 1'b0, 32'd0, 32'd0));
    chk("mflo", 76'(ex_to_mem_bus[31:0]), 76'(lo_m));
  endtask

  task automatic wait_div(input int exp_cycles);
    int n;
    n = 0;
    while (stallreq_for_ex && n < 100) begin
      n++;
      step();
    end
    chk("div_stall_cycles", 76'(n), 76'(exp_cycles));
  endtask

  task automatic do_div(input bit sgn, input logic [31:0] rs, input logic [31:0] rt);
    longint q, r;
    if (rt == 32'd0) begin
      hi_m = rs;
      lo_m = 32'hFFFF_FFFF;
    end else if (sgn) begin
      q = longint'($signed(rs)) / longint'($signed(rt));
      r = longint'($signed(rs)) % longint'($signed(rt));
      lo_m = q[31:0];
      hi_m = r[31:0];
    end else begin
      lo_m = rs / rt;
      hi_m = rs % rt;
    end
    issue(mk(32'hBFC0_0200, rtype(sgn ? 6'h1A : 6'h1B), 12'h0, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0, rs, rt));
    wait_div((rt == 32'd0) ? 1 : 33);
    read_hilo();
  endtask

  // kind: 0 mult, 1 multu, 2 mthi, 3 mtlo
  task automatic do_mul(input int kind, input logic [31:0] rs, input logic [31:0] rt);
    logic [63:0] p;
    logic [5:0]  f;
    case (kind)
      0: begin p = 64'(longint'($signed(rs)) * longint'($signed(rt))); hi_m = p[63:32]; lo_m = p[31:0]; f = 6'h18; end
      1: begin p = {32'd0, rs} * {32'd0, rt}; hi_m = p[63:32]; lo_m = p[31:0]; f = 6'h19; end
      2: begin hi_m = rs; f = 6'h11; end
      default: begin lo_m = rs; f = 6'h13; end
    endcase
    issue(mk(32'hBFC0_0300, rtype(f), 12'h0, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0, rs, rt));
    chk("mul_no_stall", 76'(stallreq_for_ex), 76'(0));
    read_hilo();
  endtask

  task automatic rand_alu();
    int k, c1, c2;
    logic [31:0] pc, inst, rs, rt, a, b, exp;
    logic [11:0] op;
    logic [4:0]  wa;
    k  = $urandom_range(0, 12);
    c1 = $urandom_range(0, 2);
    c2 = $urandom_range(0, 3);
    pc = $urandom; rs = $urandom; rt = $urandom; wa = 5'($urandom_range(1, 31));
    inst = {6'h09, 26'($urandom)};
    op = (k < 12) ? (12'h800 >> k) : 12'h000;
    a = (c1 == 1) ? pc : (c1 == 2) ? {27'd0, inst[10:6]} : rs;
    b = (c2 == 1) ? {{16{inst[15]}}, inst[15:0]} : (c2 == 2) ? 32'd8 :
        (c2 == 3) ? {16'd0, inst[15:0]} : rt;
    exp = alu_ref(k, a, b);
    issue(mk(pc, inst, op, 3'(1 << c1), 4'(1 << c2), 1'b0, 4'h0, 1'b1, wa, 1'b0, rs, rt));
    chk("alu_result", 76'(ex_to_mem_bus[31:0]), 76'(exp));
    chk("alu_rf_bus", 76'(ex_to_rf_bus), 76'({1'b1, wa, exp}));
    chk("alu_pc", 76'(ex_to_mem_bus[75:44]), 76'(pc));
    chk("alu_wen", 76'({data_sram_en, data_sram_wen}), 76'(0));
  endtask

  // typ: 0 sb, 1 sh, 2 sw, 3 lw
  task automatic mem_op(input int typ, input logic [31:0] rs, input logic [15:0] imm, input logic [31:0] rt);
    logic [31:0] addr, wd;
    logic [3:0]  wen;
    logic [5:0]  opc;
    addr = rs + {{16{imm[15]}}, imm};
    case (typ)
      0: begin opc = 6'h28; wen = 4'(1 << addr[1:0]); wd = {rt[7:0], rt[7:0], rt[7:0], rt[7:0]}; end
      1: begin opc = 6'h29; wen = addr[1] ? 4'b1100 : 4'b0011; wd = {rt[15:0], rt[15:0]}; end
      2: begin opc = 6'h2B; wen = 4'b1111; wd = rt; end
      default: begin opc = 6'h23; wen = 4'b0000; wd = 32'd0; end
    endcase
    issue(mk(32'hBFC0_0400, {opc, 10'h0, imm}, 12'h800, 3'b001, 4'b0010, 1'b1,
             (typ == 3) ? 4'h0 : 4'hF, typ == 3, 5'd9, typ == 3, rs, rt));
    chk("mem_addr", 76'(data_sram_addr), 76'(addr));
    chk("mem_wen", 76'(data_sram_wen), 76'(wen));
    chk("mem_wdata", 76'(data_sram_wdata), 76'(wd));
    chk("mem_en", 76'(data_sram_en), 76'(1));
    chk("mem_sel_rf_res", 76'(ex_to_mem_bus[38]), 76'(typ == 3));
  endtask

  logic [31:0] rs_r, rt_r;

  initial begin
    rst = 1'b0; stall = '0; stall_ovr = '0; id_to_ex_bus = '0;
    hi_m = 32'd0; lo_m = 32'd0;
    step();
    step();
    chk("reset_mem_bus", ex_to_mem_bus, 76'(0));
    chk("reset_rf_bus", 76'(ex_to_rf_bus), 76'(0));
    chk("reset_stallreq", 76'(stallreq_for_ex), 76'(0));
    chk("reset_sram", 76'({data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata}), 76'(0));
    rst = 1'b1;
    read_hilo();

    // addu 5 + 7 into r3
    issue(mk(32'hBFC0_0000, {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21}, 12'h800, 3'b001, 4'b0001,
             1'b0, 4'h0, 1'b1, 5'd3, 1'b0, 32'd5, 32'd7));
    chk("addu_result", 76'(ex_to_mem_bus[31:0]), 76'(12));
    chk("addu_rf_bus", 76'(ex_to_rf_bus), 76'({1'b1, 5'd3, 32'd12}));

    mem_op(0, 32'h1000_0002, 16'h0001, 32'h0000_00AB);
    do_div(1'b1, 32'd7, 32'hFFFF_FFFE);
    do_div(1'b0, 32'd9, 32'd0);
    do_mul(0, 32'hFFFF_FFFF, 32'd2);
    do_mul(1, 32'hFFFF_FFFF, 32'd2);
    do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: rand_alu();
        1: mem_op($urandom_range(0, 3), $urandom, 16'($urandom), $urandom);
        2: do_mul($urandom_range(0, 3), $urandom, $urandom);
        default: begin
          rs_r = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
          case ($urandom_range(0, 3))
            0: rt_r = 32'd0;
            1: rt_r = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(1, 15)) : -32'($urandom_range(1, 15));
            default: rt_r = $urandom;
          endcase
          do_div($urandom_range(0, 1) == 1, rs_r, rt_r);
        end
      endcase
    end

    // Reset in the middle of a divide clears HI/LO and drops the stall request
    do_mul(2, 32'h1234_5678, 32'd0);
    do_mul(3, 32'h9ABC_DEF0, 32'd0);
    issue(mk(32'hBFC0_0500, rtype(6'h1B), 12'h0, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0, 32'd1000, 32'd3));
    repeat (11) step();
    chk("busy_stallreq", 76'(stallreq_for_ex), 76'(1));
    rst = 1'b0;
    step();
    chk("rst_busy_stallreq", 76'(stallreq_for_ex), 76'(0));
    chk("rst_busy_mem_bus", ex_to_mem_bus, 76'(0));
    rst = 1'b1;
    hi_m = 32'd0;
    lo_m = 32'd0;
    step();
    chk("post_rst_stallreq", 76'(stallreq_for_ex), 76'(0));
    read_hilo();

    // Hold with EX and MEM stalled, then bubble with only EX stalled
    id_to_ex_bus = mk(32'hBFC0_0600, {6'h2B, 10'h0, 16'h0004}, 12'h800, 3'b001, 4'b0010,
                      1'b1, 4'hF, 1'b0, 5'd0, 1'b0, 32'h2000_0000, 32'hCAFE_F00D);
    step();
    id_to_ex_bus = '0;
    chk("sw_en", 76'(data_sram_en), 76'(1));
    stall_ovr = 6'b001100;
    step();
    chk("hold_en", 76'(data_sram_en), 76'(1));
    chk("hold_addr", 76'(data_sram_addr), 76'(32'h2000_0004));
    stall_ovr = 6'b000100;
    step();
    chk("bubble_en", 76'(data_sram_en), 76'(0));
    chk("bubble_mem_bus", ex_to_mem_bus, 76'(0));
    stall_ovr = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
